// File: rtl/cache_req_rr_arbiter_if.sv
// Request/response bundle between the cache clients, the arbiter and the tag pipeline.
// master = requester/downstream side, slave = arbiter side.
interface cache_req_rr_arbiter_if #(
    parameter int N_IN  = 4,
    parameter int IDX_W = 6,
    parameter int TAG_W = 20
);
    localparam int CHOSEN_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]       io_in_valid;
    logic [N_IN-1:0]       io_in_ready;
    logic [N_IN*IDX_W-1:0] io_in_bits_idx;
    logic [N_IN*TAG_W-1:0] io_in_bits_tag;
    logic                  io_out_valid;
    logic                  io_out_ready;
    logic [IDX_W-1:0]      io_out_bits_idx;
    logic [TAG_W-1:0]      io_out_bits_tag;
    logic [CHOSEN_W-1:0]   io_chosen;

    modport master (
        output io_in_valid, io_in_bits_idx, io_in_bits_tag, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_tag, io_chosen
    );

    modport slave (
        input  io_in_valid, io_in_bits_idx, io_in_bits_tag, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_tag, io_chosen
    );
endinterface

// File: rtl/cache_req_rr_arbiter.sv
// N-way cache request arbiter with a one-entry registered output stage.
// Define CACHE_ARB_RR_EN for round-robin; otherwise lowest channel index wins.
module cache_req_rr_arbiter #(
    parameter int N_IN  = 4,
    parameter int IDX_W = 6,
    parameter int TAG_W = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    cache_req_rr_arbiter_if.slave bus
);
    localparam int CHOSEN_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                out_valid_reg;
    logic [IDX_W-1:0]    out_idx_reg;
    logic [TAG_W-1:0]    out_tag_reg;
    logic [CHOSEN_W-1:0] out_chosen_reg;

    logic                can_load;
    logic                fire;
    logic [N_IN-1:0]     grant;
    logic [CHOSEN_W-1:0] winner;
    logic [IDX_W-1:0]    sel_idx;
    logic [TAG_W-1:0]    sel_tag;

    assign can_load = ~out_valid_reg | bus.io_out_ready;

`ifdef CACHE_ARB_RR_EN
    logic [CHOSEN_W-1:0] ptr_reg;
    logic [N_IN-1:0]     low_mask;
    logic [N_IN-1:0]     hi_req;

    // Channels below the pointer are only considered when nothing at or above it is valid.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_mask
        assign low_mask[gi] = (CHOSEN_W'(gi) < ptr_reg);
    end

    assign hi_req = bus.io_in_valid & ~low_mask;
    assign grant  = (|hi_req) ? (hi_req & ~(hi_req - N_IN'(1)))
                              : (bus.io_in_valid & ~(bus.io_in_valid - N_IN'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (fire) begin
            ptr_reg <= (winner == CHOSEN_W'(N_IN - 1)) ? '0 : winner + CHOSEN_W'(1);
        end
    end
`else
    assign grant = bus.io_in_valid & ~(bus.io_in_valid - N_IN'(1));
`endif

    // One-hot grant to channel number and selected payload.
    always_comb begin
        winner  = '0;
        sel_idx = '0;
        sel_tag = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                winner  = CHOSEN_W'(i);
                sel_idx = bus.io_in_bits_idx[i*IDX_W +: IDX_W];
                sel_tag = bus.io_in_bits_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    assign bus.io_in_ready = grant & {N_IN{can_load & ~reset}};
    assign fire            = |(bus.io_in_valid & bus.io_in_ready);

    // Stale payload is held when the stage empties; only valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_idx_reg    <= '0;
            out_tag_reg    <= '0;
            out_chosen_reg <= '0;
        end else if (fire) begin
            out_valid_reg  <= 1'b1;
            out_idx_reg    <= sel_idx;
            out_tag_reg    <= sel_tag;
            out_chosen_reg <= winner;
        end else if (can_load) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign bus.io_out_valid    = out_valid_reg;
    assign bus.io_out_bits_idx = out_idx_reg;
    assign bus.io_out_bits_tag = out_tag_reg;
    assign bus.io_chosen       = out_chosen_reg;
endmodule

// File: tb/tb_cache_req_rr_arbiter.sv
// Randomised and directed bench for cache_req_rr_arbiter against a behavioural model.
module tb_cache_req_rr_arbiter;
    localparam int N_IN  = 4;
    localparam int IDX_W = 6;
    localparam int TAG_W = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cache_req_rr_arbiter_if #(.N_IN(N_IN), .IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

    cache_req_rr_arbiter #(.N_IN(N_IN), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural model of the output stage.
    logic             m_valid  = 1'b0;
    logic [IDX_W-1:0] m_idx    = '0;
    logic [TAG_W-1:0] m_tag    = '0;
    int               m_chosen = 0;
`ifdef CACHE_ARB_RR_EN
    int               m_ptr    = 0;
`endif

    function automatic int start_pos();
`ifdef CACHE_ARB_RR_EN
        return m_ptr;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_winner(input logic [N_IN-1:0] v);
        for (int k = 0; k < N_IN; k++)
            if (v[(start_pos() + k) % N_IN]) return (start_pos() + k) % N_IN;
        return -1;
    endfunction

    function automatic logic [N_IN-1:0] exp_ready();
        if (reset || !(!m_valid || bus.io_out_ready) || exp_winner(bus.io_in_valid) < 0)
            return '0;
        return N_IN'(1) << exp_winner(bus.io_in_valid);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_idx    <= '0;
            m_tag    <= '0;
            m_chosen <= 0;
`ifdef CACHE_ARB_RR_EN
            m_ptr    <= 0;
`endif
        end else if ((!m_valid || bus.io_out_ready) && exp_winner(bus.io_in_valid) >= 0) begin
            m_valid  <= 1'b1;
            m_idx    <= bus.io_in_bits_idx[exp_winner(bus.io_in_valid)*IDX_W +: IDX_W];
            m_tag    <= bus.io_in_bits_tag[exp_winner(bus.io_in_valid)*TAG_W +: TAG_W];
            m_chosen <= exp_winner(bus.io_in_valid);
`ifdef CACHE_ARB_RR_EN
            m_ptr    <= (exp_winner(bus.io_in_valid) + 1) % N_IN;
`endif
        end else if (!m_valid || bus.io_out_ready) begin
            m_valid  <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_out_valid", 32'(bus.io_out_valid), 32'(m_valid));
        chk("model_out_idx", 32'(bus.io_out_bits_idx), 32'(m_idx));
        chk("model_out_tag", 32'(bus.io_out_bits_tag), 32'(m_tag));
        chk("model_chosen", 32'(bus.io_chosen), 32'(m_chosen));
        chk("model_in_ready", 32'(bus.io_in_ready), 32'(exp_ready()));
    end

    task automatic set_ch(input int ch, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
        bus.io_in_bits_idx[ch*IDX_W +: IDX_W] = idx;
        bus.io_in_bits_tag[ch*TAG_W +: TAG_W] = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N_IN-1:0]  fired;
    logic [IDX_W-1:0] snap_idx;
    logic [TAG_W-1:0] snap_tag;
    logic [1:0]       snap_chosen;

    initial begin
        bus.io_in_valid    = '0;
        bus.io_in_bits_idx = '0;
        bus.io_in_bits_tag = '0;
        bus.io_out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single request on channel 2.
        set_ch(2, 6'h2A, 20'hABCDE);
        bus.io_in_valid = 4'b0100;
        #1 chk("single_in_ready", 32'(bus.io_in_ready), 32'h4);
        step();
        bus.io_in_valid = '0;
        chk("single_out_valid", 32'(bus.io_out_valid), 32'd1);
        chk("single_out_idx", 32'(bus.io_out_bits_idx), 32'h2A);
        chk("single_out_tag", 32'(bus.io_out_bits_tag), 32'hABCDE);
        chk("single_chosen", 32'(bus.io_chosen), 32'd2);

        // Asynchronous reset with random inputs, observed before any clock edge.
        #1 reset = 1'b1;
        bus.io_in_valid    = N_IN'($urandom);
        bus.io_in_bits_idx = (N_IN*IDX_W)'({$urandom, $urandom});
        bus.io_in_bits_tag = (N_IN*TAG_W)'({$urandom, $urandom, $urandom});
        bus.io_out_ready   = 1'($urandom);
        #1;
        chk("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
        chk("rst_out_idx", 32'(bus.io_out_bits_idx), 32'd0);
        chk("rst_out_tag", 32'(bus.io_out_bits_tag), 32'd0);
        chk("rst_chosen", 32'(bus.io_chosen), 32'd0);
        chk("rst_in_ready", 32'(bus.io_in_ready), 32'd0);
        step();
        reset = 1'b0;

        // All channels valid with free downstream.
        for (int i = 0; i < N_IN; i++) set_ch(i, IDX_W'(i + 8), TAG_W'(i * 4097 + 3));
        bus.io_in_valid  = 4'b1111;
        bus.io_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("fair_out_valid", 32'(bus.io_out_valid), 32'd1);
`ifdef CACHE_ARB_RR_EN
            chk("fair_chosen", 32'(bus.io_chosen), 32'(k % N_IN));
`else
            chk("fair_chosen", 32'(bus.io_chosen), 32'd0);
`endif
        end

        // Back-pressure for 3 cycles, then release.
        bus.io_out_ready = 1'b0;
        #1;
        snap_idx    = bus.io_out_bits_idx;
        snap_tag    = bus.io_out_bits_tag;
        snap_chosen = bus.io_chosen;
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", 32'(bus.io_in_ready), 32'd0);
            step();
            chk("stall_out_valid", 32'(bus.io_out_valid), 32'd1);
            chk("stall_out_idx", 32'(bus.io_out_bits_idx), 32'(snap_idx));
            chk("stall_out_tag", 32'(bus.io_out_bits_tag), 32'(snap_tag));
            chk("stall_chosen", 32'(bus.io_chosen), 32'(snap_chosen));
        end
        bus.io_out_ready = 1'b1;
        #1 chk("release_in_ready", 32'(bus.io_in_ready), 32'h1);
        step();
        chk("release_out_valid", 32'(bus.io_out_valid), 32'd1);
        chk("release_chosen", 32'(bus.io_chosen), 32'd0);
        chk("release_out_idx", 32'(bus.io_out_bits_idx), 32'd8);

        // Bubble: one request then idle.
        bus.io_in_valid = 4'b0100;
        step();
        bus.io_in_valid = '0;
        chk("bubble_valid1", 32'(bus.io_out_valid), 32'd1);
        chk("bubble_chosen", 32'(bus.io_chosen), 32'd2);
        step();
        chk("bubble_valid0", 32'(bus.io_out_valid), 32'd0);
        step();
        chk("bubble_nodup", 32'(bus.io_out_valid), 32'd0);

        // Channel 0 withdrawn.
        bus.io_in_valid = 4'b1110;
        #1;
`ifdef CACHE_ARB_RR_EN
        chk("no_ch0_in_ready", 32'(bus.io_in_ready), 32'h8);
        step();
        chk("no_ch0_chosen", 32'(bus.io_chosen), 32'd3);
`else
        chk("no_ch0_in_ready", 32'(bus.io_in_ready), 32'h2);
        step();
        chk("no_ch0_chosen", 32'(bus.io_chosen), 32'd1);
`endif
        bus.io_in_valid = '0;

        // Random traffic honouring hold-until-ready, with occasional async reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            fired = bus.io_in_valid & bus.io_in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_IN; i++) begin
                if (fired[i] || !bus.io_in_valid[i]) begin
                    bus.io_in_valid[i] = ($urandom_range(0, 9) < 6);
                    set_ch(i, IDX_W'($urandom), TAG_W'($urandom));
                end
            end
            bus.io_out_ready = ($urandom_range(0, 9) < 7);
            if (c % 700 == 350) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_req_rr_arbiter.md
# cache_req_rr_arbiter

Parametrised N-way arbiter for cache request channels (set index + tag). It sits between the requesting clients and the cache tag pipeline. It selects one valid requester per cycle, by round-robin or fixed priority, and registers the winner in a one-entry output stage. The output stage provides a registered valid/bits/chosen interface with full throughput under ready/valid back-pressure.

## Interface
Parameters:
- N_IN, 4, number of requester channels (≥2)
- IDX_W, 6, set-index width
- TAG_W, 20, tag width
- CHOSEN_W, max(1, clog2(N_IN)), width of winner index (derived, not overridden)

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- io_in_valid  input  N_IN  per-channel request valid
- io_in_ready  output  N_IN  per-channel accept (one-hot or zero)
- io_in_bits_idx  input  N_IN*IDX_W  channel i occupies bits [i*IDX_W +: IDX_W]
- io_in_bits_tag  input  N_IN*TAG_W  channel i occupies bits [i*TAG_W +: TAG_W]
- io_out_valid  output  1  registered request valid
- io_out_ready  input  1  downstream accept
- io_out_bits_idx  output  IDX_W  registered winner index field
- io_out_bits_tag  output  TAG_W  registered winner tag field
- io_chosen  output  CHOSEN_W  channel number of the registered request

## Operation
- Output stage state: out_valid, out_idx, out_tag, out_chosen. Priority pointer ptr is CHOSEN_W bits.
- can_load = ~out_valid | io_out_ready.
- Arbitration is combinational over io_in_valid. The winner is the first valid channel found by searching upward from ptr, wrapping modulo N_IN.
- grant is one-hot on the winner, or zero if no channel is valid.
- io_in_ready = grant & {N_IN{can_load}}. A channel's ready depends on other channels' valid. Each input's ready does not depend on that same input's bits.
- Accept (fire) = |(io_in_valid & io_in_ready). On fire, the register loads the winner's idx, tag and channel number, and sets out_valid=1.
- If can_load and there is no fire, out_valid becomes 0. Stale bits are held.
- If out_valid & ~io_out_ready, all output registers hold and io_in_ready is all zero.
- Pointer update happens only on fire: ptr ← (winner+1) mod N_IN. At winner = N_IN-1, ptr wraps to 0. ptr is unchanged without fire, including under a stall.
- Input data is captured only at fire. Requesters must hold valid and bits stable until their ready is seen.

## Timing
- Reset (async assert, sync-safe deassert expected):
  - out_valid=0, out_idx=0, out_tag=0, out_chosen=0, ptr=0.
  - io_in_ready=0 during reset.
- Latency is 1 cycle: a fire in cycle t gives io_out_valid=1 in t+1 with the captured fields.
- Throughput is 1 request per cycle when io_out_ready is held high.
- Simultaneous drain and fill: with out_valid=1 and io_out_ready=1 while an input fires, the new request replaces the old one in the same edge, and out_valid stays 1.
- Reset asserted mid-operation discards the buffered request immediately (asynchronous). No partial transfer is reported.

## Configuration
- CACHE_ARB_RR_EN defined: round-robin arbitration as above, using ptr.
- CACHE_ARB_RR_EN undefined: fixed priority, lowest channel index wins, which extends the 2-input form to N_IN.
  - ptr is not instantiated and the search always starts at 0.
  - Output stage and handshake behaviour are identical in both builds.

## Test plan
(N_IN=4, IDX_W=6, TAG_W=20, CACHE_ARB_RR_EN defined unless noted.)
- Reset check: assert reset with random inputs.
  - Expect io_out_valid=0, io_out_bits_idx=0, io_out_bits_tag=0, io_chosen=0 and io_in_ready=4'b0000, immediately and without a clock edge.
- Single request: io_in_valid=4'b0100, ch2 idx=6'h2A, tag=20'hABCDE, io_out_ready=1.
  - Expect io_in_ready=4'b0100 in cycle 0.
  - Next cycle: io_out_valid=1, idx=6'h2A, tag=20'hABCDE, io_chosen=2.
- Round-robin fairness: all four channels held valid, io_out_ready=1 for 8 cycles.
  - io_chosen sequence is 0,1,2,3,0,1,2,3, showing pointer wrap at 3→0.
- Back-pressure: register full and io_out_ready=0 for 3 cycles with io_in_valid=4'b1111.
  - io_in_ready=0 throughout, outputs unchanged, ptr unchanged.
  - On release, the stored item drains and a new winner loads in the same edge, with io_out_valid staying 1.
- Bubble: one request, then io_in_valid=0 with io_out_ready=1.
  - io_out_valid goes 1 then 0. No duplicate request appears.
- Fixed-priority build (macro undefined): all channels valid for 4 cycles.
  - io_chosen=0 on every cycle.
  - Deasserting ch0 gives io_chosen=1.
